// File: rtl/rect_draw_pkg.sv
// rect_draw_pkg: FSM state encoding and default screen/box dimensions for rect_draw_engine.
package rect_draw_pkg;
  typedef enum logic [1:0] {IDLE, DRAW, CLEAR, DONE} state_e;
  localparam int DEF_X_SCREEN = 160;
  localparam int DEF_Y_SCREEN = 120;
  localparam int DEF_BOX_W    = 4;
  localparam int DEF_BOX_H    = 4;
  localparam int DEF_COLOUR_W = 3;
endpackage

// File: rtl/rect_draw_engine_scan.sv
// xy_scan_counter: row-major x/y counter with runtime limits; exposes the post-advance position and a last-pixel flag.
module xy_scan_counter #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clr_i,
  input  logic           en_i,
  input  logic [X_W-1:0] x_lim_i,
  input  logic [Y_W-1:0] y_lim_i,
  output logic [X_W-1:0] x_nxt_o,
  output logic [Y_W-1:0] y_nxt_o,
  output logic           last_o
);
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic           x_wrap;
  always_comb begin
    x_wrap  = x_q == x_lim_i;
    x_nxt_o = x_wrap ? '0 : x_q + 1'b1;
    y_nxt_o = !x_wrap ? y_q : (y_q == y_lim_i ? '0 : y_q + 1'b1);
    last_o  = x_wrap && y_q == y_lim_i;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (clr_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (en_i) begin
      x_q <= x_nxt_o;
      y_q <= y_nxt_o;
    end
endmodule

// File: rtl/rect_draw_engine.sv
// rect_draw_engine: draws a clipped BOX_WxBOX_H box or clears the screen, one registered pixel per cycle.
module rect_draw_engine
  import rect_draw_pkg::*;
#(
  parameter int X_SCREEN_PIXELS = DEF_X_SCREEN,
  parameter int Y_SCREEN_PIXELS = DEF_Y_SCREEN,
  parameter int BOX_W           = DEF_BOX_W,
  parameter int BOX_H           = DEF_BOX_H,
  parameter int COLOUR_W        = DEF_COLOUR_W,
  localparam int X_W            = $clog2(X_SCREEN_PIXELS),
  localparam int Y_W            = $clog2(Y_SCREEN_PIXELS)
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic                iPlotBox,
  input  logic                iBlack,
  input  logic [X_W-1:0]      iX,
  input  logic [Y_W-1:0]      iY,
  input  logic [COLOUR_W-1:0] iColour,
  output logic [X_W-1:0]      oX,
  output logic [Y_W-1:0]      oY,
  output logic [COLOUR_W-1:0] oColour,
  output logic                oPlot,
  output logic                oBusy,
  output logic                oDone
);
  state_e state_q, state_d;
  logic [X_W-1:0] x_q, x_d, ox_q, ox_d, bx, dx, nx, lim_x;
  logic [Y_W-1:0] y_q, y_d, oy_q, oy_d, by, dy, ny, lim_y;
  logic [COLOUR_W-1:0] col_q, col_d, oc_q, oc_d, bc;
  logic plot_q, plot_d, busy_q, busy_d, done_q, done_d;
  logic cnt_en, cnt_clr, cnt_last, pix;
  logic [X_W:0] sx;
  logic [Y_W:0] sy;
  assign lim_x = state_q == CLEAR ? X_W'(X_SCREEN_PIXELS - 1) : X_W'(BOX_W - 1);
  assign lim_y = state_q == CLEAR ? Y_W'(Y_SCREEN_PIXELS - 1) : Y_W'(BOX_H - 1);
  xy_scan_counter #(.X_W(X_W), .Y_W(Y_W)) u_scan (
    .clk_i(iClock), .rst_i(iReset), .clr_i(cnt_clr), .en_i(cnt_en),
    .x_lim_i(lim_x), .y_lim_i(lim_y), .x_nxt_o(nx), .y_nxt_o(ny), .last_o(cnt_last)
  );
  // The counter holds the pixel currently on the outputs; the next one is registered from its post-advance value.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    oc_d    = oc_q;
    done_d  = done_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    pix     = 1'b0;
    bx      = x_q;
    by      = y_q;
    bc      = col_q;
    dx      = nx;
    dy      = ny;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        dx      = '0;
        dy      = '0;
        if (iBlack) begin
          state_d = CLEAR;
          {x_d, y_d, col_d} = '0;
          {bx, by, bc} = '0;
          pix    = 1'b1;
          done_d = 1'b0;
        end else if (iPlotBox) begin
          state_d = DRAW;
          x_d     = iX;
          y_d     = iY;
          col_d   = iColour;
          bx      = iX;
          by      = iY;
          bc      = iColour;
          pix     = 1'b1;
          done_d  = 1'b0;
        end
      end
      DRAW, CLEAR: begin
        cnt_en  = !cnt_last;
        cnt_clr = cnt_last;
        pix     = !cnt_last;
        state_d = cnt_last ? DONE : state_q;
        done_d  = cnt_last;
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
    endcase
    sx     = {1'b0, bx} + {1'b0, dx};
    sy     = {1'b0, by} + {1'b0, dy};
    plot_d = pix && sx < (X_W+1)'(X_SCREEN_PIXELS) && sy < (Y_W+1)'(Y_SCREEN_PIXELS);
    if (plot_d) begin
      ox_d = sx[X_W-1:0];
      oy_d = sy[Y_W-1:0];
      oc_d = bc;
    end
    busy_d = state_d == DRAW || state_d == CLEAR;
  end
  always_ff @(posedge iClock or posedge iReset)
    if (iReset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      oc_q    <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      oc_q    <= oc_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  assign oX      = ox_q;
  assign oY      = oy_q;
  assign oColour = oc_q;
  assign oPlot   = plot_q;
  assign oBusy   = busy_q;
  assign oDone   = done_q;
endmodule

// File: doc/rect_draw_engine.md
RECT_DRAW_ENGINE -- requirements
Module: rect_draw_engine

Interface
REQ-001 The block SHALL have parameter X_SCREEN_PIXELS, default 160: screen width in pixels.
REQ-002 The block SHALL have parameter Y_SCREEN_PIXELS, default 120: screen height in pixels.
REQ-003 The block SHALL have parameter BOX_W, default 4: box width in pixels, range 1..X_SCREEN_PIXELS.
REQ-004 The block SHALL have parameter BOX_H, default 4: box height in pixels, range 1..Y_SCREEN_PIXELS.
REQ-005 The block SHALL have parameter COLOUR_W, default 3: colour width in bits.
REQ-006 The block SHALL derive localparams X_W = clog2(X_SCREEN_PIXELS) and Y_W = clog2(Y_SCREEN_PIXELS).
REQ-007 Port iClock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-008 Port iReset, input, 1 bit: reset, asynchronous and active-high.
REQ-009 Port iPlotBox, input, 1 bit: request to draw a box, sampled in IDLE.
REQ-010 Port iBlack, input, 1 bit: request to clear the whole screen, sampled in IDLE.
REQ-011 Port iX, input, X_W bits: box top-left x.
REQ-012 Port iY, input, Y_W bits: box top-left y.
REQ-013 Port iColour, input, COLOUR_W bits: box colour.
REQ-014 Port oX, output, X_W bits: pixel x.
REQ-015 Port oY, output, Y_W bits: pixel y.
REQ-016 Port oColour, output, COLOUR_W bits: pixel colour.
REQ-017 Port oPlot, output, 1 bit: pixel write strobe.
REQ-018 Port oBusy, output, 1 bit: high while in DRAW or CLEAR.
REQ-019 Port oDone, output, 1 bit: completion flag.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, DRAW, CLEAR and DONE.
REQ-021 In IDLE with iBlack=1, the block SHALL enter CLEAR; iBlack SHALL win when iBlack and iPlotBox are both high.
REQ-022 In IDLE with iPlotBox=1 and iBlack=0, the block SHALL latch iX, iY and iColour and enter DRAW.
REQ-023 In DRAW, the block SHALL sweep (dx,dy) row-major, dx fastest, from (0,0) to (BOX_W-1,BOX_H-1), one pixel per cycle, giving exactly BOX_W*BOX_H cycles.
REQ-024 In DRAW, the block SHALL output oX = x+dx, oY = y+dy and oColour = the latched colour, with the sums computed one bit wider than X_W/Y_W.
REQ-025 In DRAW, the block SHALL clip: when x+dx >= X_SCREEN_PIXELS or y+dy >= Y_SCREEN_PIXELS, oPlot SHALL be 0 for that cycle while the sweep still advances, so duration is fixed.
REQ-026 In CLEAR, the block SHALL sweep every pixel, (0,0) to (X_SCREEN_PIXELS-1,Y_SCREEN_PIXELS-1), row-major, with oColour=0 and oPlot=1, taking X_SCREEN_PIXELS*Y_SCREEN_PIXELS cycles.
REQ-027 The block SHALL leave DRAW or CLEAR for DONE in the cycle after its last pixel, then go from DONE to IDLE on the next cycle.
REQ-028 The first pixel SHALL appear on oX/oY/oPlot in the cycle after the request edge (latency 1), and all outputs SHALL be registered.
REQ-029 The block SHALL ignore iPlotBox and iBlack while in DRAW, CLEAR or DONE, with no queuing.
REQ-030 oDone SHALL rise when entering DONE and stay high until the next accepted request, then clear in the same cycle that oBusy rises.
REQ-031 oPlot SHALL be 0 in IDLE and DONE, and oBusy SHALL be 0 in IDLE and DONE.
REQ-032 The block SHALL hold oX, oY and oColour at their last values while oPlot is 0.

Reset
REQ-033 iReset=1 SHALL take effect immediately, without waiting for a clock edge, including mid-DRAW or mid-CLEAR.
REQ-034 On reset, the FSM SHALL go to IDLE; oX, oY, oColour, oPlot, oBusy and oDone SHALL be 0; and counters and the latched x/y/colour SHALL be 0.
REQ-035 After reset, the block SHALL accept the first request on the first rising edge after iReset is deasserted.

Structure
REQ-036 Package rect_draw_pkg SHALL hold the state enumeration and the default screen and box dimension constants.
REQ-037 The block SHALL contain one sub-module, xy_scan_counter: a row-major x/y counter with runtime limits (box or screen), an enable input, and a last-pixel flag.
REQ-038 DRAW and CLEAR SHALL share one xy_scan_counter instance.

Verification
REQ-039 Scenario, box draw: defaults; iPlotBox with iX=10, iY=20, iColour=5 -> 16 cycles of oPlot=1, oX from 10 to 13, oY from 20 to 23, oColour=5, then oDone=1.
REQ-040 Scenario, clipping: iPlotBox with iX=158, iY=118 -> 16 busy cycles, oPlot=1 only for the 4 pixels with x in {158,159} and y in {118,119}.
REQ-041 Scenario, simultaneous requests: iBlack=1 and iPlotBox=1 in the same cycle -> CLEAR runs; 19200 oPlot pulses, all oColour=0; the last pixel is (159,119).
REQ-042 Scenario, busy requests: iPlotBox pulsed in the middle of a DRAW -> ignored; total oPlot count stays 16; oDone occurs once.
REQ-043 Scenario, reset mid-CLEAR: iReset asserted at pixel 500 -> oPlot=0 with no clock edge needed; a later iPlotBox draws normally.
REQ-044 Scenario, parameter sweep: BOX_W=1, BOX_H=1 and BOX_W=7, BOX_H=3 -> durations of 1 and 21 cycles, with correct oX/oY sequences.
